// File: rtl/ld_row_packer_if.sv
// ld_row_packer_if
// Purpose: bundles the load-command, AXI read-data, SRAM write and completion
// signals of the row packer into a single interface.
// Modports:
//   slave  - the packer's view (consumes commands/beats, drives SRAM + done)
//   master - the surrounding environment's view (LSU, AXI, SRAM arbiter)
interface ld_row_packer_if #(
  parameter int BEAT_W = 64,
  parameter int ROW_W  = 128,
  parameter int ADDR_W = 8,
  parameter int ID_W   = 8
);
  logic              cmd_vld;
  logic              cmd_rdy;
  logic [ID_W-1:0]   cmd_id;
  logic [7:0]        cmd_len;
  logic [ADDR_W-1:0] cmd_sram_addr;
  logic [2:0]        cmd_str;

  logic              axi_rvld;
  logic              axi_rrdy;
  logic [ID_W-1:0]   axi_rid;
  logic [BEAT_W-1:0] axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rlast;

  logic              sram_gnt;
  logic              sram_cen;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [ROW_W-1:0]  sram_din;
  logic [ROW_W/8-1:0] sram_bwe;

  logic              done_vld;
  logic [ID_W-1:0]   done_id;
  logic              done_err;

  modport slave (
    input  cmd_vld, cmd_id, cmd_len, cmd_sram_addr, cmd_str,
    input  axi_rvld, axi_rid, axi_rdata, axi_rresp, axi_rlast,
    input  sram_gnt,
    output cmd_rdy, axi_rrdy,
    output sram_cen, sram_wen, sram_addr, sram_din, sram_bwe,
    output done_vld, done_id, done_err
  );

  modport master (
    output cmd_vld, cmd_id, cmd_len, cmd_sram_addr, cmd_str,
    output axi_rvld, axi_rid, axi_rdata, axi_rresp, axi_rlast,
    output sram_gnt,
    input  cmd_rdy, axi_rrdy,
    input  sram_cen, sram_wen, sram_addr, sram_din, sram_bwe,
    input  done_vld, done_id, done_err
  );
endinterface

// File: rtl/ld_row_packer.sv
// ld_row_packer
// Purpose: write-side stage of the DRAM-to-SRAM load path. Accepts one load
// command, consumes its AXI read beats, packs beat pairs into SRAM rows,
// writes them through the shared SRAM port and reports completion.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - ld_row_packer_if.slave (command, AXI R channel, SRAM port, done)
//
// state | meaning
// IDLE  | ready for a command
// RECV  | consuming read beats until rlast
// FLUSH | waiting for the last pending row to be written
// DONE  | one-cycle completion pulse
module ld_row_packer #(
  parameter int BEAT_W = 64,
  parameter int ROW_W  = 128,
  parameter int ADDR_W = 8,
  parameter int ID_W   = 8
) (
  input logic             clk,
  input logic             rst,
  ld_row_packer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RECV, FLUSH, DONE} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    id_q;
  logic [7:0]         len_q;
  logic [2:0]         str_q;
  logic [ADDR_W-1:0]  row_addr_q;
  logic [8:0]         beat_cnt_q;
  logic               err_q;
  logic [BEAT_W-1:0]  stage_lo_q;
  logic [ROW_W-1:0]   row_buf_q;
  logic [ROW_W/8-1:0] bwe_q;
  logic               wr_pend_q;

  logic row_beat, rrdy, beat_acc, row_done, wr_fire, beat_err, cmd_acc;

  // A beat completes a row when it is the odd half or a trailing even rlast.
  assign row_beat = beat_cnt_q[0] | bus.axi_rlast;
  // Only stall a row-completing beat when the previous row cannot leave.
  assign rrdy     = (state_q == RECV) & ~(row_beat & wr_pend_q & ~bus.sram_gnt);
  assign beat_acc = bus.axi_rvld & rrdy;
  assign row_done = beat_acc & row_beat;
  assign wr_fire  = wr_pend_q & bus.sram_gnt;
  assign cmd_acc  = (state_q == IDLE) & bus.cmd_vld;
  assign beat_err = (bus.axi_rresp != 2'd0) | (bus.axi_rid != id_q) |
                    (bus.axi_rlast & (beat_cnt_q != {1'b0, len_q})) |
                    (~bus.axi_rlast & (beat_cnt_q > {1'b0, len_q}));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.cmd_vld) state_d = RECV;
      RECV:    if (beat_acc && bus.axi_rlast) state_d = FLUSH;
      FLUSH:   if (!wr_pend_q || wr_fire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held.
  always_comb begin
    bus.cmd_rdy   = ~rst & (state_q == IDLE);
    bus.axi_rrdy  = ~rst & rrdy;
    bus.sram_cen  = ~rst & wr_fire;
    bus.sram_wen  = ~rst & wr_fire;
    bus.sram_addr = '0;
    bus.sram_din  = '0;
    bus.sram_bwe  = '0;
    if (~rst && wr_fire) begin
      bus.sram_addr = row_addr_q;
      bus.sram_din  = row_buf_q;
      bus.sram_bwe  = bwe_q;
    end
    bus.done_vld = ~rst & (state_q == DONE);
    bus.done_id  = (~rst && state_q == DONE) ? id_q : '0;
    bus.done_err = ~rst & (state_q == DONE) & err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= '0;
      len_q      <= '0;
      str_q      <= '0;
      row_addr_q <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      stage_lo_q <= '0;
      row_buf_q  <= '0;
      bwe_q      <= '0;
      wr_pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cmd_acc) begin
        id_q       <= bus.cmd_id;
        len_q      <= bus.cmd_len;
        str_q      <= bus.cmd_str;
        row_addr_q <= bus.cmd_sram_addr;
        beat_cnt_q <= '0;
        err_q      <= 1'b0;
      end else begin
        if (wr_fire) row_addr_q <= row_addr_q + ADDR_W'(str_q) + ADDR_W'(1);
        if (beat_acc && beat_cnt_q != 9'd511) beat_cnt_q <= beat_cnt_q + 9'd1;
        if (beat_acc && beat_err) err_q <= 1'b1;
      end
      if (beat_acc && !beat_cnt_q[0]) stage_lo_q <= bus.axi_rdata;
      if (row_done) begin
        if (beat_cnt_q[0]) begin
          row_buf_q <= {bus.axi_rdata, stage_lo_q};
          bwe_q     <= '1;
        end else begin
          row_buf_q <= {{(ROW_W-BEAT_W){1'b0}}, bus.axi_rdata};
          bwe_q     <= {{(ROW_W/16){1'b0}}, {(ROW_W/16){1'b1}}};
        end
      end
      // A row completing in the same cycle as a write keeps the flag set.
      wr_pend_q <= row_done | (wr_pend_q & ~wr_fire);
    end
  end
endmodule
